dct_coef_sequencer: RTL and testbench

Controller that sequences the 8-entry DCT coefficient ROM (0.5·cos(m·π/16), m = 0..7) for the 8-point 2D DCT. For every output index k and sample index n, it computes the ROM address and sign of cos((2n+1)kπ/16). It drives the ROM address/enable, tags each term with MAC first/last strobes, and steps through all lines of a row pass and then a column pass. It sits between the line buffer (line-ready handshake) and the ROM/MAC datapath.

---
 rtl/dct_pkg.sv | 40 ++++
 rtl/dct_coef_sequencer_if.sv | 33 +++
 rtl/dct_coef_index.sv | 24 ++
 rtl/dct_coef_sequencer.sv | 159 +++++++++++++++
 tb/tb_dct_coef_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// Shared types, constants and the cos((2n+1)k*pi/16) -> ROM index/sign mapping
// used by the 8-point DCT coefficient sequencer.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LINE,
    RUN,
    DONE
  } state_t;

  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam logic [LOG2N-1:0] K0_ADDR = 3'd4;

  typedef struct packed {
    logic [LOG2N-1:0] addr;
    logic neg;
  } coef_t;

  // The product reduced mod 32 picks a quadrant; quadrant 1 and 3 fold back
  // through 8-m (done as a 3-bit negation), quadrants 1 and 2 are negative.
  function automatic coef_t coef_map(input logic [LOG2N-1:0] n, input logic [LOG2N-1:0] k);
    logic [5:0] m;
    coef_t c;
    m = 6'({n, 1'b1}) * 6'(k);
    c.addr = K0_ADDR;
    c.neg = 1'b0;
    if (k != '0) begin
      case (m[4:3])
        2'b00: begin c.addr = m[2:0]; c.neg = 1'b0; end
        2'b01: begin c.addr = 3'd0 - m[2:0]; c.neg = 1'b1; end
        2'b10: begin c.addr = m[2:0]; c.neg = 1'b1; end
        default: begin c.addr = 3'd0 - m[2:0]; c.neg = 1'b0; end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dct_coef_sequencer_if.sv
// Handshake and term bus between the DCT sequencer, the line buffer and the
// ROM/MAC datapath.
interface dct_coef_sequencer_if;
  logic       start;
  logic       abort;
  logic       line_rdy;
  logic       stall;
  logic       busy;
  logic       rom_enb;
  logic [2:0] rom_addr;
  logic       coef_neg;
  logic [2:0] samp_idx;
  logic [2:0] out_idx;
  logic [2:0] line_idx;
  logic       pass;
  logic       term_valid;
  logic       mac_first;
  logic       mac_last;
  logic       line_done;
  logic       frame_done;

  modport master (
    input  start, abort, line_rdy, stall,
    output busy, rom_enb, rom_addr, coef_neg, samp_idx, out_idx, line_idx,
           pass, term_valid, mac_first, mac_last, line_done, frame_done
  );

  modport slave (
    output start, abort, line_rdy, stall,
    input  busy, rom_enb, rom_addr, coef_neg, samp_idx, out_idx, line_idx,
           pass, term_valid, mac_first, mac_last, line_done, frame_done
  );
endinterface

// File: rtl/dct_coef_index.sv
// Combinational (n, k) -> (ROM address, negate) lookup for the DCT basis.
module dct_coef_index
  import dct_pkg::*;
(
  input  logic [LOG2N-1:0] n,
  input  logic [LOG2N-1:0] k,
  output logic [LOG2N-1:0] addr,
  output logic             neg
);

  coef_t      c;
  logic [5:0] prod;

  // A multiple of 8 would mean a zero or unit coefficient the ROM cannot hold.
  always_comb begin
    c = coef_map(n, k);
    prod = 6'({n, 1'b1}) * 6'(k);
    if (k != '0) assert (prod[2:0] != 3'd0);
  end

  assign addr = c.addr;
  assign neg  = c.neg;

endmodule

// File: rtl/dct_coef_sequencer.sv
// Steps (pass, line, k, n) through a row pass and a column pass, issuing one
// registered coefficient term per consumed cycle to the ROM/MAC datapath.
module dct_coef_sequencer
  import dct_pkg::*;
#(
  parameter int LINES  = 8,
  parameter int PASSES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dct_coef_sequencer_if.master bus
);

  localparam logic [LOG2N-1:0] LAST_LINE = 3'(LINES - 1);
  localparam logic             LAST_PASS = 1'(PASSES - 1);

  state_t state, state_next;

  logic [LOG2N-1:0] n_q, k_q, line_q;
  logic [LOG2N-1:0] n_d, k_d, line_d;
  logic             pass_q, pass_d;
  logic             hold, line_done_d, frame_done_d;
  logic [LOG2N-1:0] addr_d;
  logic             neg_d;
  logic             run_next;

  logic             busy_q, run_q, neg_q, first_q, last_q;
  logic             line_done_q, frame_done_q;
  logic [LOG2N-1:0] addr_q;

  // Coefficient is looked up for the term about to be registered.
  dct_coef_index u_index (
    .n    (n_d),
    .k    (k_d),
    .addr (addr_d),
    .neg  (neg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    n_d          = n_q;
    k_d          = k_q;
    line_d       = line_q;
    pass_d       = pass_q;
    hold         = 1'b0;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = WAIT_LINE;
          n_d        = '0;
          k_d        = '0;
          line_d     = '0;
          pass_d     = 1'b0;
        end
      end
      WAIT_LINE: begin
        if (bus.line_rdy) begin
          state_next = RUN;
          n_d        = '0;
          k_d        = '0;
        end
      end
      RUN: begin
        if (bus.stall) begin
          hold = 1'b1;
        end else begin
          n_d = n_q + 3'd1;
          if (n_q == 3'd7) k_d = k_q + 3'd1;
          if (n_q == 3'd7 && k_q == 3'd7) begin
            line_done_d = 1'b1;
            if (line_q == LAST_LINE && pass_q == LAST_PASS) begin
              state_next = DONE;
            end else begin
              state_next = WAIT_LINE;
              if (line_q == LAST_LINE) begin
                line_d = '0;
                pass_d = 1'b1;
              end else begin
                line_d = line_q + 3'd1;
              end
            end
          end
        end
      end
      DONE: begin
        state_next   = IDLE;
        frame_done_d = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a pending stall or pulse.
    if (bus.abort) begin
      state_next   = IDLE;
      hold         = 1'b0;
      line_done_d  = 1'b0;
      frame_done_d = 1'b0;
    end
    if (state_next == IDLE) begin
      n_d    = '0;
      k_d    = '0;
      line_d = '0;
      pass_d = 1'b0;
    end
  end

  assign run_next = (state_next == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q          <= '0;
      k_q          <= '0;
      line_q       <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      run_q        <= 1'b0;
      addr_q       <= '0;
      neg_q        <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (!hold) begin
      n_q          <= n_d;
      k_q          <= k_d;
      line_q       <= line_d;
      pass_q       <= pass_d;
      busy_q       <= (state_next != IDLE);
      run_q        <= run_next;
      addr_q       <= run_next ? addr_d : '0;
      neg_q        <= run_next && neg_d;
      first_q      <= run_next && (n_d == 3'd0);
      last_q       <= run_next && (n_d == 3'd7);
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rom_enb    = run_q;
  assign bus.term_valid = run_q;
  assign bus.rom_addr   = addr_q;
  assign bus.coef_neg   = neg_q;
  assign bus.samp_idx   = n_q;
  assign bus.out_idx    = k_q;
  assign bus.line_idx   = line_q;
  assign bus.pass       = pass_q;
  assign bus.mac_first  = first_q;
  assign bus.mac_last   = last_q;
  assign bus.line_done  = line_done_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_dct_coef_sequencer.sv
// Self-checking bench for dct_coef_sequencer: mapping table, then whole frames
// checked cycle by cycle against a term-count model with cosine-derived coefficients.
module tb_dct_coef_sequencer;
  import dct_pkg::*;

  localparam int  LINES  = 8;
  localparam int  PASSES = 2;
  localparam int  TERMS  = 64 * LINES * PASSES;
  localparam real PI     = 3.14159265358979;

  localparam int P_WAIT = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
  localparam int P_IDLE = 3;

  typedef struct {
    int k;
    int n;
    int addr;
    bit neg;
  } map_vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_coef_sequencer_if bus ();

  dct_coef_sequencer #(.LINES(LINES), .PASSES(PASSES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] tn, tk, taddr;
  logic       tneg;

  dct_coef_index u_index_chk (
    .n    (tn),
    .k    (tk),
    .addr (taddr),
    .neg  (tneg)
  );

  int checks = 0;
  int passed = 0;
  int line_len[LINES*PASSES];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference coefficient: sign and nearest ROM entry of the true cosine.
  function automatic void refCoef(input int k, input int n, output int addr, output bit neg);
    real c, a, d, best;
    addr = 4;
    neg  = 1'b0;
    if (k != 0) begin
      c    = $cos(real'((2 * n + 1) * k) * PI / 16.0);
      neg  = (c < 0.0);
      a    = neg ? -c : c;
      best = 10.0;
      for (int m = 1; m < 8; m++) begin
        d = $cos(real'(m) * PI / 16.0) - a;
        if (d < 0.0) d = -d;
        if (d < best) begin
          best = d;
          addr = m;
        end
      end
    end
  endfunction

  function automatic logic [20:0] outVec();
    return {bus.busy, bus.rom_enb, bus.rom_addr, bus.coef_neg, bus.samp_idx, bus.out_idx,
            bus.line_idx, bus.pass, bus.term_valid, bus.mac_first, bus.mac_last,
            bus.line_done, bus.frame_done};
  endfunction

  // Runs one frame (or until abort) with the given stimulus shaping, checking every cycle.
  task automatic applyStimulus(input int stall_pct, input int rdy_pct, input int stall_at,
                               input int stall_len, input int gap_line, input int abort_at,
                               input int start_at, output int busy_cycles, output int ld_count);
    int   e, phase, cur_len, stall_used, gap_used, idle_cnt, ref_addr;
    bit   ref_neg, exp_tv, exp_ld, exp_fd, exp_busy, ended;
    logic [19:0] exp_term;
    int   kk, nn, ln, ps;
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.stall    = 1'b0;
    bus.line_rdy = 1'b0;
    stepCycle();
    bus.start   = 1'b0;
    e           = 0;
    phase       = P_WAIT;
    exp_tv      = 1'b0;
    exp_ld      = 1'b0;
    exp_fd      = 1'b0;
    exp_busy    = 1'b1;
    cur_len     = 0;
    stall_used  = 0;
    gap_used    = 0;
    idle_cnt    = 0;
    busy_cycles = 0;
    ld_count    = 0;
    ended       = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      kk = (e / 8) % 8;
      nn = e % 8;
      ln = (e / 64) % LINES;
      ps = e / (64 * LINES);
      checkOutput("ctrl", 32'({bus.busy, bus.rom_enb, bus.term_valid, bus.line_done, bus.frame_done}),
                  32'({exp_busy, exp_tv, exp_tv, exp_ld, exp_fd}));
      if (phase == P_IDLE) begin
        checkOutput("idle_zero", 32'(outVec() >> 1), 32'd0);
      end else if (phase == P_RUN) begin
        refCoef(kk, nn, ref_addr, ref_neg);
        exp_term = {ps[0], ln[2:0], kk[2:0], nn[2:0], ref_addr[2:0], ref_neg, 1'b1,
                    (nn == 0), (nn == 7), 1'b0};
        checkOutput($sformatf("term_e%0d", e),
                    32'({bus.pass, bus.line_idx, bus.out_idx, bus.samp_idx, bus.rom_addr,
                         bus.coef_neg, bus.rom_enb, bus.mac_first, bus.mac_last, 1'b0}),
                    32'(exp_term));
        cur_len++;
      end else if (phase == P_WAIT) begin
        checkOutput("wait_line_pos", 32'({bus.pass, bus.line_idx}), 32'({ps[0], ln[2:0]}));
      end
      if (bus.busy) busy_cycles++;
      if (bus.line_done) ld_count++;
      if (exp_fd || (phase == P_IDLE && idle_cnt >= 5)) begin
        ended = 1'b1;
        break;
      end
      bus.stall    = (int'($urandom_range(99)) < stall_pct);
      bus.line_rdy = (int'($urandom_range(99)) < rdy_pct);
      bus.abort    = 1'b0;
      bus.start    = 1'b0;
      if (phase == P_RUN && e == stall_at) begin
        bus.stall = (stall_used < stall_len);
        if (bus.stall) stall_used++;
      end
      if (phase == P_WAIT && e == 64 * gap_line && gap_used < 10) begin
        bus.line_rdy = 1'b0;
        gap_used++;
      end
      if (phase == P_RUN && e == start_at) bus.start = 1'b1;
      if (phase == P_RUN && e == abort_at) bus.abort = 1'b1;
      exp_ld = 1'b0;
      exp_fd = 1'b0;
      if (bus.abort) begin
        phase    = P_IDLE;
        exp_tv   = 1'b0;
        exp_busy = 1'b0;
      end else begin
        case (phase)
          P_WAIT: if (bus.line_rdy) begin
            phase  = P_RUN;
            exp_tv = 1'b1;
          end
          P_RUN: if (!bus.stall) begin
            e++;
            if (e % 64 == 0) begin
              exp_ld = 1'b1;
              exp_tv = 1'b0;
              line_len[e/64-1] = cur_len;
              cur_len = 0;
              phase = (e == TERMS) ? P_DONE : P_WAIT;
            end
          end
          P_DONE: begin
            exp_fd   = 1'b1;
            exp_busy = 1'b0;
            phase    = P_IDLE;
          end
          default: idle_cnt++;
        endcase
      end
      stepCycle();
    end
    checkOutput("frame_end_reached", 32'(ended), 32'd1);
    bus.stall    = 1'b0;
    bus.line_rdy = 1'b0;
    bus.abort    = 1'b0;
    bus.start    = 1'b0;
  endtask

  initial begin
    map_vec_t map_tab[9];
    int bc, ldc, ra;
    bit rn;
    map_tab[0] = '{k: 0, n: 0, addr: 4, neg: 1'b0};
    map_tab[1] = '{k: 0, n: 5, addr: 4, neg: 1'b0};
    map_tab[2] = '{k: 0, n: 7, addr: 4, neg: 1'b0};
    map_tab[3] = '{k: 1, n: 0, addr: 1, neg: 1'b0};
    map_tab[4] = '{k: 1, n: 7, addr: 1, neg: 1'b1};
    map_tab[5] = '{k: 2, n: 3, addr: 2, neg: 1'b1};
    map_tab[6] = '{k: 4, n: 1, addr: 4, neg: 1'b1};
    map_tab[7] = '{k: 7, n: 7, addr: 7, neg: 1'b1};
    map_tab[8] = '{k: 3, n: 2, addr: 1, neg: 1'b1};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.line_rdy = 1'b0;
    bus.stall    = 1'b0;
    tn           = '0;
    tk           = '0;
    repeat (2) stepCycle();
    checkOutput("reset_outputs", 32'(outVec()), 32'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("idle_after_reset", 32'(outVec()), 32'd0);

    foreach (map_tab[i]) begin
      tk = 3'(map_tab[i].k);
      tn = 3'(map_tab[i].n);
      #1;
      checkOutput($sformatf("map_k%0d_n%0d", map_tab[i].k, map_tab[i].n),
                  32'({taddr, tneg}), 32'({map_tab[i].addr[2:0], map_tab[i].neg}));
    end
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        tk = 3'(k);
        tn = 3'(n);
        #1;
        refCoef(k, n, ra, rn);
        checkOutput($sformatf("cos_k%0d_n%0d", k, n), 32'({taddr, tneg}), 32'({ra[2:0], rn}));
      end
    end
    stepCycle();

    $display("[TB] full frame, line_rdy held high");
    applyStimulus(0, 100, -1, 0, -1, -1, -1, bc, ldc);
    checkOutput("min_frame_busy_cycles", 32'(bc), 32'(LINES * PASSES * 65 + 1));
    checkOutput("line_done_count", 32'(ldc), 32'(LINES * PASSES));

    $display("[TB] stall at k3 n5, 10-cycle line_rdy gap, start during RUN");
    applyStimulus(0, 100, 29, 5, 1, -1, 200, bc, ldc);
    checkOutput("stalled_line_len", 32'(line_len[0]), 32'd69);
    checkOutput("gap_frame_busy_cycles", 32'(bc), 32'(LINES * PASSES * 65 + 1 + 5 + 10));

    $display("[TB] abort at line 2 k 4");
    applyStimulus(0, 100, -1, 0, -1, 2 * 64 + 4 * 8, -1, bc, ldc);
    checkOutput("abort_line_done_count", 32'(ldc), 32'd2);

    $display("[TB] restart with random stall and line_rdy");
    applyStimulus(30, 60, -1, 0, -1, -1, -1, bc, ldc);
    checkOutput("random_line_done_count", 32'(ldc), 32'(LINES * PASSES));

    $display("[TB] asynchronous reset mid-RUN");
    bus.start = 1'b1;
    stepCycle();
    bus.start    = 1'b0;
    bus.line_rdy = 1'b1;
    repeat (20) stepCycle();
    checkOutput("run_before_reset", 32'(bus.term_valid), 32'd1);
    #3 rst = 1'b1;
    #1 checkOutput("async_reset_zero", 32'(outVec()), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("post_reset_quiet", 32'(outVec()), 32'd0);
    end
    bus.line_rdy = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
